// File: rtl/filtro_pkg.sv
// rtl/filtro_pkg.sv - shared constants, FSM states and coefficient reset helper for filtro_cascada
package filtro_pkg;

    localparam logic [2:0] COEF_B0 = 3'd0;
    localparam logic [2:0] COEF_B1 = 3'd1;
    localparam logic [2:0] COEF_B2 = 3'd2;
    localparam logic [2:0] COEF_A1 = 3'd3;
    localparam logic [2:0] COEF_A2 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_OUT
    } state_t;

    // Fixed-point 1.0 for a format with frac fraction bits.
    function automatic logic [63:0] coef_one(input int frac);
        return 64'd1 << frac;
    endfunction

endpackage

// File: rtl/filtro_cascada_if.sv
// rtl/filtro_cascada_if.sv - sample, coefficient and status bundle for filtro_cascada
interface filtro_cascada_if #(
    parameter int Width = 32,
    parameter int N_SEC = 2
);
    localparam int SEC_W = (N_SEC > 1) ? $clog2(N_SEC) : 1;

    logic                    enable;
    logic signed [Width-1:0] uk;
    logic                    coef_we;
    logic [SEC_W-1:0]        coef_sec;
    logic [2:0]              coef_sel;
    logic signed [Width-1:0] coef_data;
    logic signed [Width-1:0] yk;
    logic                    valid;
    logic                    busy;
    logic                    overrun;

    modport master (
        output enable, uk, coef_we, coef_sec, coef_sel, coef_data,
        input  yk, valid, busy, overrun
    );

    modport slave (
        input  enable, uk, coef_we, coef_sec, coef_sel, coef_data,
        output yk, valid, busy, overrun
    );

endinterface

// File: rtl/filtro_mac.sv
// rtl/filtro_mac.sv - shared multiply-accumulate with floor shift and Width reduction
// Reduction saturates when FILTRO_SAT_EN is defined, otherwise wraps.
module filtro_mac #(
    parameter int Width = 32,
    parameter int f     = 18
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [Width-1:0] op_a_i,
    input  logic signed [Width-1:0] op_b_i,
    input  logic                    clear_i,
    input  logic                    accum_i,
    input  logic                    negate_i,
    output logic signed [Width-1:0] result_o
);
    localparam int PW = 2 * Width;
    localparam int AW = 2 * Width + 3;

    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] term;
    logic signed [AW-1:0] acc_q, acc_d;

    always_comb begin
        prod  = PW'(op_a_i) * PW'(op_b_i);
        term  = negate_i ? -AW'(prod) : AW'(prod);
        acc_d = acc_q;
        if (accum_i) begin
            acc_d = clear_i ? term : acc_q + term;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef FILTRO_SAT_EN
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-Width+1){1'b0}}, {(Width-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-Width+1){1'b1}}, {(Width-1){1'b0}}};

    logic signed [AW-1:0] shifted;

    always_comb begin
        shifted = acc_q >>> f;
        if (shifted > SAT_MAX) begin
            result_o = SAT_MAX[Width-1:0];
        end else if (shifted < SAT_MIN) begin
            result_o = SAT_MIN[Width-1:0];
        end else begin
            result_o = shifted[Width-1:0];
        end
    end
`else
    assign result_o = Width'(acc_q >>> f);
`endif

endmodule

// File: rtl/filtro_cascada.sv
// rtl/filtro_cascada.sv - N_SEC-section Direct Form I biquad cascade on one shared MAC
// Optional saturation of section results is selected with FILTRO_SAT_EN.
module filtro_cascada
    import filtro_pkg::*;
#(
    parameter int p     = 13,
    parameter int f     = 18,
    parameter int Width = p + f + 1,
    parameter int N_SEC = 2
) (
    input  logic          clk,
    input  logic          rst,
    filtro_cascada_if.slave bus
);
    localparam int SEC_W = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam int HW    = $clog2(N_SEC + 1);

    typedef logic signed [Width-1:0] word_t;
    localparam word_t COEF_RESET = word_t'(coef_one(f));

    word_t            coef_q  [N_SEC][5];
    word_t            snap_q  [N_SEC][5];
    word_t            hist1_q [N_SEC+1];
    word_t            hist2_q [N_SEC+1];
    word_t            cur_x_q, yk_q;
    state_t           state_q;
    logic [SEC_W-1:0] sec_q;
    logic [2:0]       ph_q;
    logic             valid_q, busy_q, overrun_q;

    word_t            op_a, op_b, mac_res;
    logic [HW-1:0]    hcur, hnext, hprev;
    logic             coef_ok;

    always_comb begin
        hcur    = HW'(sec_q);
        hnext   = hcur + HW'(1);
        hprev   = hcur - HW'(1);
        op_b    = snap_q[sec_q][ph_q];
        coef_ok = bus.coef_we && ({1'b0, bus.coef_sec} < (SEC_W+1)'(N_SEC))
                  && (bus.coef_sel <= COEF_A2);
        // Product 0 of a later section takes the previous section's result straight from the MAC.
        case (ph_q)
            3'd0:    op_a = (sec_q == '0) ? cur_x_q : mac_res;
            3'd1:    op_a = hist1_q[hcur];
            3'd2:    op_a = hist2_q[hcur];
            3'd3:    op_a = hist1_q[hnext];
            default: op_a = hist2_q[hnext];
        endcase
    end

    filtro_mac #(.Width(Width), .f(f)) u_mac (
        .clk      (clk),
        .rst      (rst),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .clear_i  (ph_q == 3'd0),
        .accum_i  (state_q == ST_MAC),
        .negate_i (ph_q >= 3'd3),
        .result_o (mac_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N_SEC; s++) begin
                for (int c = 0; c < 5; c++) begin
                    coef_q[s][c] <= (c == 0) ? COEF_RESET : '0;
                    snap_q[s][c] <= '0;
                end
            end
            for (int h = 0; h <= N_SEC; h++) begin
                hist1_q[h] <= '0;
                hist2_q[h] <= '0;
            end
            cur_x_q   <= '0;
            yk_q      <= '0;
            state_q   <= ST_IDLE;
            sec_q     <= '0;
            ph_q      <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (coef_ok) begin
                        coef_q[bus.coef_sec][bus.coef_sel] <= bus.coef_data;
                    end
                    if (bus.enable) begin
                        snap_q  <= coef_q;
                        cur_x_q <= bus.uk;
                        sec_q   <= '0;
                        ph_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    overrun_q <= bus.enable;
                    // A section boundary: retire the finished section's input history.
                    if (ph_q == 3'd0 && sec_q != '0) begin
                        hist2_q[hprev] <= hist1_q[hprev];
                        hist1_q[hprev] <= cur_x_q;
                        cur_x_q        <= mac_res;
                    end
                    if (ph_q == 3'd4) begin
                        ph_q <= '0;
                        if (sec_q == SEC_W'(N_SEC - 1)) begin
                            state_q <= ST_OUT;
                        end else begin
                            sec_q <= sec_q + SEC_W'(1);
                        end
                    end else begin
                        ph_q <= ph_q + 3'd1;
                    end
                end
                ST_OUT: begin
                    overrun_q      <= bus.enable;
                    hist2_q[hcur]  <= hist1_q[hcur];
                    hist1_q[hcur]  <= cur_x_q;
                    hist2_q[hnext] <= hist1_q[hnext];
                    hist1_q[hnext] <= mac_res;
                    yk_q           <= mac_res;
                    valid_q        <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.yk      = yk_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;

endmodule
